// File: rtl/ball_motion_ctrl_pkg.sv
// Shared types and playfield defaults for the ball motion engine.
// State encoding, coordinate widths and the wall-limit helper live here.
package ball_pkg;

  typedef enum logic {
    SERVE = 1'b0,
    MOVE  = 1'b1
  } state_e;

  localparam int unsigned H_MAX     = 256;
  localparam int unsigned V_MAX     = 240;
  localparam int unsigned BALL_SIZE = 4;

  localparam int unsigned POS_W = 9;
  localparam int unsigned VEL_W = 10;

  // Largest legal left/top coordinate so the whole ball stays inside the field.
  function automatic logic [POS_W-1:0] wall_limit(input int unsigned max_px,
                                                  input int unsigned size_px);
    return POS_W'(max_px - size_px);
  endfunction

endpackage

// File: rtl/ball_motion_ctrl_axis_reflect.sv
// One axis of ball motion: advance by velocity and mirror off 0 / limit.
// Purely combinational; instantiated once per axis by ball_motion_ctrl.
module axis_reflect
  import ball_pkg::*;
(
  input  logic        [POS_W-1:0] pos,
  input  logic signed [VEL_W-1:0] vel,
  input  logic        [POS_W-1:0] limit,
  output logic        [POS_W-1:0] next_pos,
  output logic signed [VEL_W-1:0] next_vel,
  output logic                    hit
);

  logic signed [VEL_W-1:0] sum;
  logic signed [VEL_W-1:0] lim_s;
  logic signed [VEL_W-1:0] refl;

  always_comb begin
    sum      = $signed({1'b0, pos}) + vel;
    lim_s    = $signed({1'b0, limit});
    refl     = (lim_s <<< 1) - sum;
    next_pos = pos;
    next_vel = vel;
    hit      = 1'b0;
    // Landing exactly on 0 or limit is legal; only overshoot reflects.
    if (sum < 0) begin
      next_pos = POS_W'(-sum);
      next_vel = -vel;
      hit      = 1'b1;
    end else if (sum > lim_s) begin
      next_pos = POS_W'(refl);
      next_vel = -vel;
      hit      = 1'b1;
    end else begin
      next_pos = POS_W'(sum);
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Frame-rate ball motion engine: serve hold, wall reflection, hit pulses.
// Motion advances once per vsync rising edge in the pixel clock domain.
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int unsigned H_MAX        = ball_pkg::H_MAX,
  parameter int unsigned V_MAX        = ball_pkg::V_MAX,
  parameter int unsigned BALL_SIZE    = ball_pkg::BALL_SIZE,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned INIT_H       = 128,
  parameter int unsigned INIT_V       = 128,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             restart,
  input  logic             freeze,
  output logic [POS_W-1:0] ball_hpos,
  output logic [POS_W-1:0] ball_vpos,
  output logic             hit_h,
  output logic             hit_v,
  output logic             serving
);

  localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic        [POS_W-1:0] H_LIM   = wall_limit(H_MAX, BALL_SIZE);
  localparam logic        [POS_W-1:0] V_LIM   = wall_limit(V_MAX, BALL_SIZE);
  localparam logic        [POS_W-1:0] INIT_HP = POS_W'(INIT_H);
  localparam logic        [POS_W-1:0] INIT_VP = POS_W'(INIT_V);
  localparam logic signed [VEL_W-1:0] SPEED_V = VEL_W'(SPEED);
  localparam logic        [CNT_W-1:0] CNT_END = CNT_W'(SERVE_FRAMES);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [POS_W-1:0]         hpos_q, hpos_d;
  logic [POS_W-1:0]         vpos_q, vpos_d;
  logic signed [VEL_W-1:0]  vel_h_q, vel_h_d;
  logic signed [VEL_W-1:0]  vel_v_q, vel_v_d;
  logic                     hit_h_q, hit_h_d;
  logic                     hit_v_q, hit_v_d;
  logic                     vsync_q;

  logic                     tick;
  logic [CNT_W-1:0]         cnt_inc;
  logic [POS_W-1:0]         h_next_pos, v_next_pos;
  logic signed [VEL_W-1:0]  h_next_vel, v_next_vel;
  logic                     h_hit, v_hit;

  axis_reflect u_axis_h (
    .pos      (hpos_q),
    .vel      (vel_h_q),
    .limit    (H_LIM),
    .next_pos (h_next_pos),
    .next_vel (h_next_vel),
    .hit      (h_hit)
  );

  axis_reflect u_axis_v (
    .pos      (vpos_q),
    .vel      (vel_v_q),
    .limit    (V_LIM),
    .next_pos (v_next_pos),
    .next_vel (v_next_vel),
    .hit      (v_hit)
  );

  assign tick    = vsync & ~vsync_q;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    vel_h_d = vel_h_q;
    vel_v_d = vel_v_q;
    hit_h_d = 1'b0;
    hit_v_d = 1'b0;
    // restart beats a coincident tick and alternates the horizontal serve direction.
    if (restart) begin
      state_d = SERVE;
      cnt_d   = '0;
      hpos_d  = INIT_HP;
      vpos_d  = INIT_VP;
      vel_h_d = -vel_h_q;
      vel_v_d = SPEED_V;
    end else if (tick && !freeze) begin
      unique case (state_q)
        SERVE: begin
          if (cnt_inc == CNT_END) begin
            state_d = MOVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        MOVE: begin
          hpos_d  = h_next_pos;
          vpos_d  = v_next_pos;
          vel_h_d = h_next_vel;
          vel_v_d = v_next_vel;
          hit_h_d = h_hit;
          hit_v_d = v_hit;
        end
        default: state_d = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SERVE;
      cnt_q   <= '0;
      hpos_q  <= INIT_HP;
      vpos_q  <= INIT_VP;
      vel_h_q <= -SPEED_V;
      vel_v_q <= SPEED_V;
      hit_h_q <= 1'b0;
      hit_v_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      vel_h_q <= vel_h_d;
      vel_v_q <= vel_v_d;
      hit_h_q <= hit_h_d;
      hit_v_q <= hit_v_d;
      vsync_q <= vsync;
    end
  end

  assign ball_hpos = hpos_q;
  assign ball_vpos = vpos_q;
  assign hit_h     = hit_h_q;
  assign hit_v     = hit_v_q;
  assign serving   = (state_q == SERVE);

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed self-checking bench for ball_motion_ctrl: serve, bounces, corner,
// freeze/restart interaction and asynchronous reset.
`timescale 1ns/1ps
module tb_ball_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0, restart = 1'b0, freeze = 1'b0;
  logic       vsync_c = 1'b0, restart_c = 1'b0, freeze_c = 1'b0;
  logic [8:0] hpos, vpos, c_hpos, c_vpos;
  logic       hit_h, hit_v, serving, c_hit_h, c_hit_v, c_serving;

  logic a_h1, a_v1, a_h2, a_v2, c_h1, c_v1, c_h2, c_v2;
  logic any_h, any_v;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ball_motion_ctrl #(.SERVE_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .restart(restart), .freeze(freeze),
    .ball_hpos(hpos), .ball_vpos(vpos), .hit_h(hit_h), .hit_v(hit_v),
    .serving(serving)
  );

  ball_motion_ctrl #(.INIT_H(2), .INIT_V(234), .SERVE_FRAMES(1)) dut_c (
    .clk(clk), .reset(reset), .vsync(vsync_c), .restart(restart_c),
    .freeze(freeze_c), .ball_hpos(c_hpos), .ball_vpos(c_vpos),
    .hit_h(c_hit_h), .hit_v(c_hit_v), .serving(c_serving)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One vsync rising edge; hits captured in the tick's result cycle and the next.
  task automatic pulse(input bit sel);
    @(negedge clk);
    if (sel) vsync_c = 1'b1; else vsync = 1'b1;
    @(negedge clk);
    a_h1 = hit_h; a_v1 = hit_v; c_h1 = c_hit_h; c_v1 = c_hit_v;
    vsync = 1'b0; vsync_c = 1'b0;
    @(negedge clk);
    a_h2 = hit_h; a_v2 = hit_v; c_h2 = c_hit_h; c_v2 = c_hit_v;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (hpos !== 9'd128) begin errors++; $display("FAIL reset_hpos got %0d want 128", hpos); end
    checks++; if (vpos !== 9'd128) begin errors++; $display("FAIL reset_vpos got %0d want 128", vpos); end
    checks++; if (serving !== 1'b1) begin errors++; $display("FAIL reset_serving got %b want 1", serving); end
    checks++; if ({hit_h, hit_v} !== 2'b00) begin errors++; $display("FAIL reset_hits got %b%b want 00", hit_h, hit_v); end
    checks++; if ({c_hpos, c_vpos} !== {9'd2, 9'd234}) begin errors++; $display("FAIL reset_corner_pos got %0d,%0d want 2,234", c_hpos, c_vpos); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_serve();
    pulse(0);
    checks++; if ({hpos, vpos} !== {9'd128, 9'd128}) begin errors++; $display("FAIL serve_t1_pos got %0d,%0d want 128,128", hpos, vpos); end
    checks++; if (serving !== 1'b1) begin errors++; $display("FAIL serve_t1_serving got %b want 1", serving); end
    pulse(0);
    checks++; if ({hpos, vpos} !== {9'd128, 9'd128}) begin errors++; $display("FAIL serve_t2_pos got %0d,%0d want 128,128", hpos, vpos); end
    checks++; if (serving !== 1'b0) begin errors++; $display("FAIL serve_t2_serving got %b want 0", serving); end
    checks++; if ({a_h1, a_v1} !== 2'b00) begin errors++; $display("FAIL serve_hits got %b%b want 00", a_h1, a_v1); end
    pulse(0);
    checks++; if ({hpos, vpos} !== {9'd126, 9'd130}) begin errors++; $display("FAIL move_t1_pos got %0d,%0d want 126,130", hpos, vpos); end
  endtask

  task automatic test_bounce();
    any_h = 1'b0; any_v = 1'b0;
    for (int k = 2; k <= 54; k++) begin
      pulse(0); any_h |= a_h1; any_v |= a_v1;
    end
    checks++; if ({hpos, vpos} !== {9'd20, 9'd236}) begin errors++; $display("FAIL move_t54_pos got %0d,%0d want 20,236", hpos, vpos); end
    checks++; if ({any_h, any_v} !== 2'b00) begin errors++; $display("FAIL move_t54_nohit got %b%b want 00", any_h, any_v); end
    pulse(0);
    checks++; if ({hpos, vpos} !== {9'd18, 9'd234}) begin errors++; $display("FAIL bottom_pos got %0d,%0d want 18,234", hpos, vpos); end
    checks++; if ({a_h1, a_v1, a_v2} !== 3'b010) begin errors++; $display("FAIL bottom_hit_pulse got h%b v%b v_next%b want h0 v1 v_next0", a_h1, a_v1, a_v2); end
    pulse(0);
    checks++; if ({hpos, vpos} !== {9'd16, 9'd232}) begin errors++; $display("FAIL bottom_vel_pos got %0d,%0d want 16,232", hpos, vpos); end
    any_h = 1'b0; any_v = 1'b0;
    for (int k = 57; k <= 64; k++) begin
      pulse(0); any_h |= a_h1; any_v |= a_v1;
    end
    checks++; if ({hpos, vpos} !== {9'd0, 9'd216}) begin errors++; $display("FAIL move_t64_pos got %0d,%0d want 0,216", hpos, vpos); end
    checks++; if ({any_h, any_v} !== 2'b00) begin errors++; $display("FAIL left_edge_nohit got %b%b want 00", any_h, any_v); end
    pulse(0);
    checks++; if ({hpos, vpos} !== {9'd2, 9'd214}) begin errors++; $display("FAIL left_pos got %0d,%0d want 2,214", hpos, vpos); end
    checks++; if ({a_h1, a_h2, a_v1} !== 3'b100) begin errors++; $display("FAIL left_hit_pulse got h%b h_next%b v%b want h1 h_next0 v0", a_h1, a_h2, a_v1); end
    pulse(0);
    checks++; if ({hpos, vpos} !== {9'd4, 9'd212}) begin errors++; $display("FAIL left_vel_pos got %0d,%0d want 4,212", hpos, vpos); end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    any_h = 1'b0; any_v = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pulse(0); any_h |= a_h1; any_v |= a_v1;
    end
    checks++; if ({hpos, vpos} !== {9'd4, 9'd212}) begin errors++; $display("FAIL freeze_pos got %0d,%0d want 4,212", hpos, vpos); end
    checks++; if ({any_h, any_v} !== 2'b00) begin errors++; $display("FAIL freeze_hits got %b%b want 00", any_h, any_v); end
    freeze = 1'b0;
  endtask

  task automatic test_restart();
    @(negedge clk);
    vsync = 1'b1; restart = 1'b1;
    @(negedge clk);
    vsync = 1'b0; restart = 1'b0;
    checks++; if ({hpos, vpos} !== {9'd128, 9'd128}) begin errors++; $display("FAIL restart_pos got %0d,%0d want 128,128", hpos, vpos); end
    checks++; if (serving !== 1'b1) begin errors++; $display("FAIL restart_serving got %b want 1", serving); end
    checks++; if ({hit_h, hit_v} !== 2'b00) begin errors++; $display("FAIL restart_hits got %b%b want 00", hit_h, hit_v); end
    repeat (3) pulse(0);
    checks++; if ({hpos, vpos} !== {9'd126, 9'd130}) begin errors++; $display("FAIL restart1_dir got %0d,%0d want 126,130", hpos, vpos); end
    freeze = 1'b1;
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    checks++; if ({serving, hpos, vpos} !== {1'b1, 9'd128, 9'd128}) begin errors++; $display("FAIL restart_frozen got s%b %0d,%0d want s1 128,128", serving, hpos, vpos); end
    freeze = 1'b0;
    repeat (3) pulse(0);
    checks++; if ({hpos, vpos} !== {9'd130, 9'd130}) begin errors++; $display("FAIL restart2_dir got %0d,%0d want 130,130", hpos, vpos); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({hpos, vpos} !== {9'd128, 9'd128}) begin errors++; $display("FAIL async_pos got %0d,%0d want 128,128", hpos, vpos); end
    checks++; if ({serving, hit_h, hit_v} !== 3'b100) begin errors++; $display("FAIL async_flags got s%b h%b v%b want s1 h0 v0", serving, hit_h, hit_v); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); vsync = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (serving !== 1'b1) begin errors++; $display("FAIL long_vsync_serving got %b want 1", serving); end
    vsync = 1'b0;
    @(negedge clk);
    pulse(0);
    checks++; if ({serving, hpos, vpos} !== {1'b0, 9'd128, 9'd128}) begin errors++; $display("FAIL post_reset_serve got s%b %0d,%0d want s0 128,128", serving, hpos, vpos); end
    pulse(0);
    checks++; if ({hpos, vpos} !== {9'd126, 9'd130}) begin errors++; $display("FAIL post_reset_move got %0d,%0d want 126,130", hpos, vpos); end
  endtask

  task automatic test_corner();
    pulse(1);
    checks++; if ({c_serving, c_hpos, c_vpos} !== {1'b0, 9'd2, 9'd234}) begin errors++; $display("FAIL corner_serve got s%b %0d,%0d want s0 2,234", c_serving, c_hpos, c_vpos); end
    pulse(1);
    checks++; if ({c_hpos, c_vpos} !== {9'd0, 9'd236}) begin errors++; $display("FAIL corner_t1_pos got %0d,%0d want 0,236", c_hpos, c_vpos); end
    checks++; if ({c_h1, c_v1} !== 2'b00) begin errors++; $display("FAIL corner_t1_hits got %b%b want 00", c_h1, c_v1); end
    pulse(1);
    checks++; if ({c_hpos, c_vpos} !== {9'd2, 9'd234}) begin errors++; $display("FAIL corner_t2_pos got %0d,%0d want 2,234", c_hpos, c_vpos); end
    checks++; if ({c_h1, c_v1, c_h2, c_v2} !== 4'b1100) begin errors++; $display("FAIL corner_t2_hits got %b%b then %b%b want 11 then 00", c_h1, c_v1, c_h2, c_v2); end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_bounce();
    test_freeze();
    test_restart();
    test_async_reset();
    test_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
